// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter
//   Two-master pipelined-Wishbone arbiter in front of a single SDRAM
//   controller port. Masters m0/m1 get round-robin ownership while idle;
//   the owner's request passes straight through to the s_* port. An
//   outstanding-request counter caps accepted-but-unacknowledged strobes
//   at MAX_OUTSTANDING. A DRAIN state absorbs the acks still in flight
//   when an owner drops cyc early.
//
//   Optional feature (macro SDRAM_ARB_QUANTUM_EN): after QUANTUM accepted
//   strobes in one grant, the owner is stalled whenever the other master
//   is requesting, and ownership is handed over through DRAIN and IDLE.
//
// Ports
//   clk, reset_n                   clock, async active-low reset
//   mN_cyc_i/stb_i/we_i            master N cycle, strobe, write enable
//   mN_addr_i, mN_data_i           master N address and write data
//   mN_data_o                      read data (s_data_i to both masters)
//   mN_stall_o, mN_ack_o           master N stall and acknowledge
//   s_cyc_o/stb_o/we_o             request to SDRAM controller
//   s_addr_o, s_data_o             address and write data to controller
//   s_data_i, s_stall_i, s_ack_i   controller read data, stall, ack
//   grant_o                        one-hot owner, 00 while IDLE

module sdram_wb_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8,
    parameter int QUANTUM         = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // master 0
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_stall_o,
    output logic                  m0_ack_o,
    // master 1
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_stall_o,
    output logic                  m1_ack_o,
    // SDRAM controller
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_stall_i,
    input  logic                  s_ack_i,
    // ownership
    output logic [1:0]            grant_o
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;

    state_t        state;
    logic [OW-1:0] outstanding;
    logic          last_m1;     // 1: m1 was granted most recently, so m0 wins a tie
    logic          own0;
    logic          own1;
    logic          full;
    logic          accept;
    logic          q_hold;      // owner has used up its quantum and must yield

    assign own0   = (state == GRANT0);
    assign own1   = (state == GRANT1);
    assign full   = (outstanding == OW'(MAX_OUTSTANDING));
    assign accept = s_stb_o & ~s_stall_i;

    // Read data is broadcast; only the owner ever sees an ack.
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

`ifdef SDRAM_ARB_QUANTUM_EN
    localparam int QW = $clog2(QUANTUM + 1);

    logic [QW-1:0] q_cnt;
    logic          q_other;

    assign q_other = own0 ? m1_cyc_i : m0_cyc_i;
    assign q_hold  = (own0 | own1) & (q_cnt == QW'(QUANTUM)) & q_other;

    // Every grant is entered from IDLE, so clearing there clears it on
    // entry to GRANTN. Saturates so a lone master can keep streaming.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_cnt <= '0;
        end else if (state == IDLE) begin
            q_cnt <= '0;
        end else if (accept && (q_cnt != QW'(QUANTUM))) begin
            q_cnt <= q_cnt + 1'b1;
        end
    end
`else
    assign q_hold = 1'b0;
`endif

    // Owner's request passes through; everyone else is stalled.
    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_o   = '0;
        s_data_o   = '0;
        m0_stall_o = 1'b1;
        m1_stall_o = 1'b1;
        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        case (state)
            GRANT0: begin
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i & ~full & ~q_hold;
                s_we_o     = m0_we_i;
                s_addr_o   = m0_addr_i;
                s_data_o   = m0_data_i;
                m0_stall_o = s_stall_i | full | q_hold;
                m0_ack_o   = s_ack_i;
            end
            GRANT1: begin
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i & ~full & ~q_hold;
                s_we_o     = m1_we_i;
                s_addr_o   = m1_addr_i;
                s_data_o   = m1_data_i;
                m1_stall_o = s_stall_i | full | q_hold;
                m1_ack_o   = s_ack_i;
            end
            // Keep the bus cycle open so the controller can return the
            // acks it still owes; they go nowhere.
            DRAIN:   s_cyc_o = 1'b1;
            default: ;
        endcase
    end

    // Accept and ack in the same cycle cancel out. An ack with nothing
    // outstanding is ignored so the counter cannot underflow; the stall
    // rule keeps accepts from pushing it past MAX_OUTSTANDING.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else if (accept && !s_ack_i) begin
            outstanding <= outstanding + 1'b1;
        end else if (!accept && s_ack_i && (outstanding != '0)) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            last_m1 <= 1'b1;
            grant_o <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_m1)) begin
                        state   <= GRANT0;
                        grant_o <= 2'b01;
                        last_m1 <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state   <= GRANT1;
                        grant_o <= 2'b10;
                        last_m1 <= 1'b1;
                    end
                end
                GRANT0: begin
                    if (!m0_cyc_i) begin
                        if (outstanding == '0) begin
                            state   <= IDLE;
                            grant_o <= 2'b00;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (q_hold) begin
                        state <= DRAIN;
                    end
                end
                GRANT1: begin
                    if (!m1_cyc_i) begin
                        if (outstanding == '0) begin
                            state   <= IDLE;
                            grant_o <= 2'b00;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (q_hold) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // grant_o keeps the previous owner's bit until IDLE
                    if (outstanding == '0) begin
                        state   <= IDLE;
                        grant_o <= 2'b00;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench for sdram_wb_arbiter (MAX_OUTSTANDING=8, QUANTUM=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge or 1 ns after the rising edge.

module tb_sdram_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m0_stall_o, m0_ack_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        m1_stall_o, m1_ack_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_stall_i, s_ack_i;
    logic [1:0]  grant_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_wb_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(8), .QUANTUM(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
        .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
        .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
        .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    task automatic idle_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_data_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_data_i = '0;
        s_stall_i = 0; s_ack_i = 0; s_data_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; s_ack_i = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0000", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o});
        end
        checks++;
        if ({m0_stall_o, m1_stall_o} !== 2'b11) begin
            errors++; $display("FAIL reset_stall: got %b expected 11", {m0_stall_o, m1_stall_o});
        end
        checks++;
        if (grant_o !== 2'b00) begin
            errors++; $display("FAIL reset_grant: got %b expected 00", grant_o);
        end
        idle_inputs();
        reset_n = 1;
        @(posedge clk); #1;
        checks++;
        if ({grant_o, s_cyc_o} !== 3'b000) begin
            errors++; $display("FAIL idle_after_reset: got %b expected 000", {grant_o, s_cyc_o});
        end
    endtask

    task automatic test_single_master();
        int beats = 0; int acks = 0; int n = 0;
        logic acc;
        logic [31:0] exp_v;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_addr_i = 32'h0; m0_data_i = 32'hD000_0000;
        @(negedge clk);
        checks++;
        if (s_cyc_o !== 1'b0) begin
            errors++; $display("FAIL grant_latency: s_cyc_o got %b expected 0 before edge", s_cyc_o);
        end
        while (acks < 16 && n < 100) begin
            @(negedge clk);
            n++;
            acc = s_stb_o & ~s_stall_i;
            checks++;
            if (grant_o !== 2'b01 || s_cyc_o !== 1'b1) begin
                errors++; $display("FAIL single_grant: grant %b cyc %b expected 01 1", grant_o, s_cyc_o);
            end
            if (acc) begin
                exp_v = 32'(beats * 4);
                checks++;
                if (s_addr_o !== exp_v || s_we_o !== 1'b1 || s_data_o !== (32'hD000_0000 | exp_v)) begin
                    errors++; $display("FAIL single_beat: addr %h data %h expected %h %h", s_addr_o, s_data_o, exp_v, 32'hD000_0000 | exp_v);
                end
                beats++;
            end
            if (m0_ack_o) begin
                exp_v = 32'h5A00_0000 + 32'(acks);
                checks++;
                if (m0_data_o !== exp_v || m1_data_o !== exp_v || m1_ack_o !== 1'b0) begin
                    errors++; $display("FAIL single_read: m0 %h m1 %h expected %h", m0_data_o, m1_data_o, exp_v);
                end
                acks++;
            end
            @(posedge clk); #1;
            s_ack_i = acc;
            s_data_i = 32'h5A00_0000 + 32'(beats - 1);
            if (acc) begin
                if (beats == 16) m0_stb_i = 0;
                m0_addr_i = 32'(beats * 4);
                m0_data_i = 32'hD000_0000 | 32'(beats * 4);
            end
        end
        checks++;
        if (beats != 16 || acks != 16) begin
            errors++; $display("FAIL single_counts: beats %0d acks %0d expected 16 16", beats, acks);
        end
        s_ack_i = 0;
        m0_cyc_i = 0;
        @(posedge clk); #1;
        checks++;
        if ({grant_o, s_cyc_o} !== 3'b000) begin
            errors++; $display("FAIL single_to_idle: got %b expected 000", {grant_o, s_cyc_o});
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        do_reset();
        m0_cyc_i = 1; m1_cyc_i = 1;
        @(posedge clk); #1;
        checks++;
        if (grant_o !== 2'b01) begin
            errors++; $display("FAIL rr_first: got %b expected 01", grant_o);
        end
        s_ack_i = 1; #1;
        checks++;
        if ({m0_ack_o, m1_ack_o, m1_stall_o} !== 3'b101) begin
            errors++; $display("FAIL ack_routing: got %b expected 101", {m0_ack_o, m1_ack_o, m1_stall_o});
        end
        s_ack_i = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (grant_o !== 2'b01) begin
            errors++; $display("FAIL rr_hold: got %b expected 01", grant_o);
        end
        m0_cyc_i = 0;
        while (grant_o !== 2'b10 && n < 4) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (grant_o !== 2'b10 || n > 2) begin
            errors++; $display("FAIL rr_handover: grant %b after %0d cycles expected 10 within 2", grant_o, n);
        end
        m1_stb_i = 1; m1_we_i = 0; m1_addr_i = 32'h0000_1234; s_stall_i = 1; #1;
        checks++;
        if ({s_stb_o, s_we_o, m1_stall_o, m0_stall_o} !== 4'b1011 || s_addr_o !== 32'h0000_1234) begin
            errors++; $display("FAIL m1_passthru: got %b addr %h expected 1011 00001234", {s_stb_o, s_we_o, m1_stall_o, m0_stall_o}, s_addr_o);
        end
        m1_stb_i = 0; s_stall_i = 0; m1_cyc_i = 0;
        @(posedge clk); #1;
        m0_cyc_i = 1; m1_cyc_i = 1;
        @(posedge clk); #1;
        checks++;
        if (grant_o !== 2'b01) begin
            errors++; $display("FAIL rr_alt_m0: got %b expected 01", grant_o);
        end
        m0_cyc_i = 0; m1_cyc_i = 0;
        @(posedge clk); #1;
        m0_cyc_i = 1; m1_cyc_i = 1;
        @(posedge clk); #1;
        checks++;
        if (grant_o !== 2'b10) begin
            errors++; $display("FAIL rr_alt_m1: got %b expected 10", grant_o);
        end
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_outstanding_limit();
        int acc_n = 0;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        repeat (14) begin
            @(negedge clk);
            if (s_stb_o && !s_stall_i) acc_n++;
            @(posedge clk); #1;
        end
        checks++;
        if (acc_n != 8) begin
            errors++; $display("FAIL limit_accepts: got %0d expected 8", acc_n);
        end
        @(negedge clk);
        checks++;
        if ({m0_stall_o, s_stb_o} !== 2'b10) begin
            errors++; $display("FAIL limit_stall: got %b expected 10", {m0_stall_o, s_stb_o});
        end
        @(posedge clk); #1;
        s_ack_i = 1;
        @(negedge clk);
        checks++;
        if (m0_stall_o !== 1'b1) begin
            errors++; $display("FAIL limit_ack_cycle: stall got %b expected 1", m0_stall_o);
        end
        @(posedge clk); #1;
        s_ack_i = 0;
        @(negedge clk);
        checks++;
        if ({m0_stall_o, s_stb_o} !== 2'b01) begin
            errors++; $display("FAIL limit_release: got %b expected 01", {m0_stall_o, s_stb_o});
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_drain();
        int acc_n = 0; int n = 0;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        while (acc_n < 3 && n < 20) begin
            @(negedge clk);
            if (s_stb_o && !s_stall_i) acc_n++;
            @(posedge clk); #1; n++;
        end
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 1;
        checks++;
        if (acc_n != 3) begin
            errors++; $display("FAIL drain_setup: accepts %0d expected 3", acc_n);
        end
        @(posedge clk); #1;
        checks++;
        if ({grant_o, s_cyc_o, s_stb_o, m0_stall_o, m1_stall_o} !== 6'b011011) begin
            errors++; $display("FAIL drain_state: got %b expected 011011", {grant_o, s_cyc_o, s_stb_o, m0_stall_o, m1_stall_o});
        end
        for (int k = 0; k < 3; k++) begin
            s_ack_i = 1;
            @(negedge clk);
            checks++;
            if ({m0_ack_o, m1_ack_o} !== 2'b00) begin
                errors++; $display("FAIL drain_ack_drop: got %b expected 00", {m0_ack_o, m1_ack_o});
            end
            @(posedge clk); #1;
            s_ack_i = 0;
            if (k < 2) begin
                @(negedge clk);
                checks++;
                if (grant_o !== 2'b01) begin
                    errors++; $display("FAIL drain_hold: got %b expected 01", grant_o);
                end
                @(posedge clk); #1;
            end
        end
        n = 0;
        while (grant_o !== 2'b00 && n < 3) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (grant_o !== 2'b00) begin
            errors++; $display("FAIL drain_to_idle: got %b expected 00", grant_o);
        end
        @(posedge clk); #1;
        checks++;
        if (grant_o !== 2'b10) begin
            errors++; $display("FAIL drain_then_m1: got %b expected 10", grant_o);
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

`ifdef SDRAM_ARB_QUANTUM_EN
    task automatic test_quantum();
        int acc_n = 0; int n = 0;
        logic acc; logic saw_idle = 0;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m1_cyc_i = 1;
        while (grant_o !== 2'b10 && n < 40) begin
            @(negedge clk);
            acc = s_stb_o & ~s_stall_i;
            if (acc && grant_o == 2'b01) acc_n++;
            if (grant_o == 2'b00 && acc_n > 0) saw_idle = 1;
            @(posedge clk); #1;
            s_ack_i = acc; n++;
        end
        s_ack_i = 0;
        checks++;
        if (acc_n != 4 || !saw_idle || grant_o !== 2'b10) begin
            errors++; $display("FAIL quantum_handover: accepts %0d idle %b grant %b expected 4 1 10", acc_n, saw_idle, grant_o);
        end
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
    endtask
`else
    task automatic test_grant_hold();
        int acc_n = 0; int n = 0;
        logic acc; logic moved = 0;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m1_cyc_i = 1;
        @(posedge clk); #1;
        while (acc_n < 12 && n < 40) begin
            @(negedge clk);
            acc = s_stb_o & ~s_stall_i;
            if (acc) acc_n++;
            if (grant_o !== 2'b01) moved = 1;
            @(posedge clk); #1;
            s_ack_i = acc; n++;
        end
        m0_stb_i = 0;
        @(posedge clk); #1;
        s_ack_i = 0;
        checks++;
        if (acc_n != 12 || moved) begin
            errors++; $display("FAIL grant_hold: accepts %0d moved %b expected 12 0", acc_n, moved);
        end
        m0_cyc_i = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (grant_o !== 2'b10) begin
            errors++; $display("FAIL hold_release: got %b expected 10", grant_o);
        end
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_reset_mid_burst();
        int acc_n = 0; int n = 0;
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 32'h0000_0100;
        while (acc_n < 3 && n < 20) begin
            @(negedge clk);
            if (s_stb_o && !s_stall_i) acc_n++;
            @(posedge clk); #1; n++;
        end
        #2;
        reset_n = 0; s_ack_i = 1;
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o, grant_o, m1_stall_o, m1_ack_o} !== 6'b000010) begin
            errors++; $display("FAIL reset_mid: got %b expected 000010", {s_cyc_o, s_stb_o, grant_o, m1_stall_o, m1_ack_o});
        end
        @(posedge clk); #1;
        idle_inputs();
        reset_n = 1;
        @(posedge clk); #1;
        checks++;
        if ({grant_o, s_cyc_o} !== 3'b000) begin
            errors++; $display("FAIL post_reset_idle: got %b expected 000", {grant_o, s_cyc_o});
        end
        acc_n = 0;
        m0_cyc_i = 1; m0_stb_i = 1;
        repeat (14) begin
            @(negedge clk);
            if (s_stb_o && !s_stall_i) acc_n++;
            @(posedge clk); #1;
        end
        checks++;
        if (acc_n != 8) begin
            errors++; $display("FAIL post_reset_counter: accepts %0d expected 8", acc_n);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_master();
        test_round_robin();
        test_outstanding_limit();
        test_drain();
`ifdef SDRAM_ARB_QUANTUM_EN
        test_quantum();
`else
        test_grant_hold();
`endif
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
